// File: rtl/comparator_seq_if.sv
// Start/busy/done handshake bundle for comparator_seq: operands and mode in, status and one-hot result out.
// Master launches operations; slave is the comparator.
interface comparator_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, a_gt_b, a_eq_b, a_lt_b
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, a_gt_b, a_eq_b, a_lt_b
    );
endinterface

// File: rtl/comparator_seq.sv
// Multi-cycle magnitude comparator, CHUNK bits per clock, MSB chunk first; signed via MSB-flip to offset binary.
// Latency: first differing chunk position with COMPARATOR_SEQ_EARLY_EXIT_EN, otherwise always NCHUNK edges.
// Backpressure: start is ignored while busy; nothing is queued. Start during the done cycle is accepted.
module comparator_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    comparator_seq_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic             chunk_gt;
    logic             chunk_lt;
    logic             last;
    logic             launch;
    logic             decide;
    logic             dec_gt;
    logic             dec_lt;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
    // First differing chunk is remembered while the remaining chunks are walked.
    logic             pend_vld;
    logic             pend_gt;
`endif

    // Operands shift left each CMP cycle so the chunk under test is always on top.
    assign chunk_a  = a_q[WIDTH-1 -: CHUNK];
    assign chunk_b  = b_q[WIDTH-1 -: CHUNK];
    assign chunk_gt = chunk_a > chunk_b;
    assign chunk_lt = chunk_a < chunk_b;
    assign last     = (idx == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        decide    = 1'b0;
        dec_gt    = 1'b0;
        dec_lt    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = CMP;
                    launch    = 1'b1;
                end
            end
            CMP: begin
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
                if (chunk_gt || chunk_lt || last) begin
                    decide = 1'b1;
                    dec_gt = chunk_gt;
                    dec_lt = chunk_lt;
                end
`else
                if (last) begin
                    decide = 1'b1;
                    if (pend_vld) begin
                        dec_gt = pend_gt;
                        dec_lt = !pend_gt;
                    end else begin
                        dec_gt = chunk_gt;
                        dec_lt = chunk_lt;
                    end
                end
`endif
                if (decide) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_nxt = CMP;
                    launch    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            idx  <= '0;
            gt_q <= 1'b0;
            eq_q <= 1'b0;
            lt_q <= 1'b0;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
            pend_vld <= 1'b0;
            pend_gt  <= 1'b0;
`endif
        end else begin
            if (launch) begin
                a_q <= {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
                b_q <= {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
                idx <= '0;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
                pend_vld <= 1'b0;
`endif
            end else if (state == CMP) begin
                a_q <= a_q << CHUNK;
                b_q <= b_q << CHUNK;
                idx <= idx + 1'b1;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
                if (!pend_vld && (chunk_gt || chunk_lt)) begin
                    pend_vld <= 1'b1;
                    pend_gt  <= chunk_gt;
                end
`endif
            end
            if (decide) begin
                gt_q <= dec_gt;
                lt_q <= dec_lt;
                eq_q <= !(dec_gt || dec_lt);
            end
        end
    end

    assign bus.busy   = (state == CMP);
    assign bus.done   = (state == DONE);
    assign bus.a_gt_b = gt_q;
    assign bus.a_eq_b = eq_q;
    assign bus.a_lt_b = lt_q;
endmodule

// File: tb/tb_comparator_seq.sv
// Self-checking bench for comparator_seq (WIDTH=16, CHUNK=4): directed cases then randomized operations.
// Expected results come from plain integer compares; latency from the first differing chunk.
module tb_comparator_seq;
    localparam int W   = 16;
    localparam int CH  = 4;
    localparam int NCH = W / CH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    comparator_seq_if #(.WIDTH(W)) bus ();

    comparator_seq #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer compare for the result; latency from where the raw operands first differ.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sm,
                         output logic eg, output logic ee, output logic el, output int lat);
        int first;
        bit found;
        if (sm) begin
            eg = $signed(av) > $signed(bv);
            el = $signed(av) < $signed(bv);
        end else begin
            eg = av > bv;
            el = av < bv;
        end
        ee    = (av == bv);
        first = NCH;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && (((av >> (W - CH * (i + 1))) & 16'hF) != ((bv >> (W - CH * (i + 1))) & 16'hF))) begin
                first = i + 1;
                found = 1'b1;
            end
        end
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
        lat = first;
`else
        lat = NCH;
`endif
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.done && lat < 40);
    endtask

    task automatic check_flags(input string tag, input logic eg, input logic ee, input logic el);
        chk({tag, "_gt"}, {31'd0, bus.a_gt_b}, {31'd0, eg});
        chk({tag, "_eq"}, {31'd0, bus.a_eq_b}, {31'd0, ee});
        chk({tag, "_lt"}, {31'd0, bus.a_lt_b}, {31'd0, el});
    endtask

    // Launch one operation (back-to-back if called in the done cycle) and check latency and result.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sm, input string tag);
        logic eg, ee, el;
        int   exp_lat, lat;
        model(av, bv, sm, eg, ee, el, exp_lat);
        @(negedge clk);
        bus.start = 1'b1; bus.a = av; bus.b = bv; bus.signed_mode = sm;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.signed_mode = ~sm;
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        wait_done(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
        check_flags(tag, eg, ee, el);
    endtask

    initial begin
        logic eg, ee, el;
        int   lat, exp_lat, done_seen;
        bus.start = 1'b1; bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0;

        // Reset with start asserted: start must be ignored.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);

        run_op(16'h1234, 16'h1234, 1'b0, "eq_u");
        repeat (3) @(posedge clk);
        #1;
        check_flags("hold", 1'b0, 1'b1, 1'b0);
        run_op(16'h8000, 16'h7FFF, 1'b0, "msb_u");
        run_op(16'h8000, 16'h7FFF, 1'b1, "msb_s");

        // Start pulsed at E2 while busy must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h00F0; bus.b = 16'h00F1; bus.signed_mode = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'hFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 2;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.done && lat < 40);
        chk("ign_lat", lat, 32'd4);
        check_flags("ign", 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("ign_no_relaunch", {31'd0, bus.busy}, 32'd0);
        chk("ign_done_pulse", {31'd0, bus.done}, 32'd0);

        // Back-to-back pairs: second launch lands in the done cycle of the first.
        run_op(16'hFFFF, 16'h0001, 1'b1, "b2b_a");
        run_op(16'hFFFF, 16'h0001, 1'b0, "b2b_b");
        run_op(16'h0000, 16'h0000, 1'b1, "b2b_c");

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (16'h1 << $urandom_range(0, W - 1));
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom), "rnd");
            if ($urandom_range(0, 1) == 0) begin
                repeat (2) @(posedge clk);
            end
        end

        // Reset mid-operation: no done, flags back to zero.
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0002; bus.signed_mode = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        check_flags("mid_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done) done_seen++;
        end
        chk("mid_rst_no_done", done_seen, 32'd0);
        check_flags("mid_rst_after", 1'b0, 1'b0, 1'b0);

        // One last operation after reset confirms recovery.
        model(16'h0001, 16'h0002, 1'b0, eg, ee, el, exp_lat);
        run_op(16'h0001, 16'h0002, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/comparator_seq.md
Name: comparator_seq

Overview:
- Parametrised, multi-cycle magnitude comparator. Compares two WIDTH-bit operands CHUNK bits per clock, most significant chunk first.
- Operand pair is launched with a start/busy/done handshake and supports unsigned or two's-complement signed mode per operation.
- Produces registered, one-hot greater/equal/less flags.
- Used where wide operands must be compared without a single wide combinational compare on the critical path.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK and at least 2.
- CHUNK, 4, bits compared per clock; 1 <= CHUNK <= WIDTH.
- NCHUNK is derived as WIDTH/CHUNK and is not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch request; sampled only when busy=0.
- a  input  WIDTH  operand A; sampled on the accepted start edge.
- b  input  WIDTH  operand B; sampled on the accepted start edge.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- busy  output  1  comparison in progress.
- done  output  1  one-cycle pulse when results update.
- a_gt_b  output  1  registered result: A > B.
- a_eq_b  output  1  registered result: A == B.
- a_lt_b  output  1  registered result: A < B.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy, done, a_gt_b, a_eq_b, a_lt_b all 0; chunk index 0.
  - Reset overrides start and any in-flight compare. A comparison cut off by reset produces no done and no result update.
- FSM states: IDLE, CMP, DONE.
  - IDLE: busy=0, done=0. On start=1, go to CMP.
  - CMP: busy=1. Each edge compares chunk idx, starting at idx=0, which holds bits [WIDTH-1 -: CHUNK].
  - DONE: a single cycle with done=1 and busy=0. Returns to IDLE, or to CMP if start=1 in that cycle (back-to-back accepted).
- Operand capture:
  - On an accepted start edge, a, b and signed_mode are latched internally.
  - Later input changes have no effect on that operation.
- Start handling: start while busy=1 is ignored, with no queueing.
- Signed mode: the operand MSB (bit WIDTH-1) of both latched operands is inverted before comparison, converting them to offset binary. The unsigned chunk compare then yields the signed result.
- Chunk compare:
  - If chunk_a > chunk_b, decide GT. If chunk_a < chunk_b, decide LT.
  - Otherwise advance idx. If idx was NCHUNK-1, decide EQ.
- On decision:
  - Next state is DONE. Exactly one result flag is set and the other two are cleared, all on the same edge that raises done.
  - Result flags hold their value until the next done. Between operations the flags are stable and reflect the last result.
- Latency: done rises N edges after the accepted start edge, where N = 1-based position of the first differing chunk, or NCHUNK if the operands are equal. Maximum is NCHUNK.
- Throughput: one new operation per N+1 cycles (start may be held high continuously).
- Invariant: after the first completion, exactly one of a_gt_b/a_eq_b/a_lt_b is 1. Before the first completion after reset, all three are 0.
- Edge cases:
  - CHUNK=WIDTH gives a fixed 1-cycle latency.
  - WIDTH=4, CHUNK=4 is functionally equivalent to a registered 4-bit comparator.

Optional Feature:
- Macro: COMPARATOR_SEQ_EARLY_EXIT_EN.
- Defined: the FSM leaves CMP at the first differing chunk (latency as above).
- Undefined:
  - The FSM always walks all NCHUNK chunks; the first differing chunk still determines the result.
  - done always rises exactly NCHUNK edges after start, giving constant latency for timing-deterministic users.
  - Results are identical in both builds.

Test Plan (WIDTH=16, CHUNK=4, edge E0 = accepted start):
- Reset: hold rst 2 cycles -> busy=0, done=0, all three flags 0. start=1 during rst is ignored.
- Equal, unsigned: a=0x1234, b=0x1234, signed_mode=0 -> done at E4, a_eq_b=1, other flags 0.
- MSB differ, unsigned: a=0x8000, b=0x7FFF, signed_mode=0 -> a_gt_b=1, done at E1 with EARLY_EXIT_EN, at E4 without.
- Same operands, signed: a=0x8000 (-32768), b=0x7FFF -> a_lt_b=1, same latency as the previous case.
- LSB-chunk differ plus ignored start: a=0x00F0, b=0x00F1, then pulse start again with a=0xFFFF at E2 -> ignored; done at E4 with a_lt_b=1. Back-to-back start in the DONE cycle is accepted.
- Reset mid-operation: a=0x0001, b=0x0002 started, rst=1 at E2 -> after that edge busy=0, done never pulses, flags keep their reset value 0.
